// File: rtl/min_receive_fsm_if.sv
// Byte-stream and decoded-frame signals between a UART receive path and the MIN receive decoder.
interface min_receive_fsm_if #(
    parameter int MAX_PAYLOAD = 4,
    parameter int LEN_WIDTH   = 8
);
    logic                     i_en;
    logic                     i_valid;
    logic [7:0]               i_data;
    logic                     o_valid;
    logic [7:0]               o_id;
    logic [LEN_WIDTH-1:0]     o_len;
    logic [8*MAX_PAYLOAD-1:0] o_data;
    logic                     o_err;
    logic [1:0]               o_err_code;
    logic                     o_busy;

    // Byte source side: drives raw bytes, observes decoded frames
    modport master (
        output i_en, i_valid, i_data,
        input  o_valid, o_id, o_len, o_data, o_err, o_err_code, o_busy
    );

    // Decoder side
    modport slave (
        input  i_en, i_valid, i_data,
        output o_valid, o_id, o_len, o_data, o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/min_receive_fsm.sv
// MIN frame receive decoder: strips AA AA 55 stuffing, parses id/len/payload,
// checks CRC-32 and the 0x55 EOF byte, and reports each frame as a valid or error pulse.
module min_receive_fsm #(
    parameter int MAX_PAYLOAD = 4,
    parameter int LEN_WIDTH   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    min_receive_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        S_SOF,
        S_ID,
        S_LEN,
        S_PAYLOAD,
        S_CRC,
        S_EOF
    } state_e;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    state_e                   state_q, state_d;
    logic [1:0]               aaCnt_q, aaCnt_d;
    logic [31:0]              crcCalc_q, crcCalc_d;
    logic [31:0]              crcRx_q, crcRx_d;
    logic [7:0]               id_q, id_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
    logic [LEN_WIDTH-1:0]     byteCnt_q, byteCnt_d;
    logic [1:0]               crcCnt_q, crcCnt_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [1:0]               errCode_q, errCode_d;
    logic [7:0]               outId_q, outId_d;
    logic [LEN_WIDTH-1:0]     outLen_q, outLen_d;
    logic [8*MAX_PAYLOAD-1:0] outData_q, outData_d;

    logic                     strobe;
    logic                     isHeader;
    logic                     isStuff;
    logic                     dataStrobe;
    logic                     lenTooBig;
    logic                     crcOk;
    logic [31:0]              crcNext;

    // One byte of reflected CRC-32, processed LSB first as eight shift/xor steps
    function automatic logic [31:0] crcByte(input logic [31:0] crcIn, input logic [7:0] dataIn);
        logic [31:0] r;
        r = crcIn ^ {24'd0, dataIn};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign strobe     = bus.i_en && bus.i_valid;
    assign isHeader   = strobe && (bus.i_data == 8'hAA) && (aaCnt_q == 2'd2);
    assign isStuff    = strobe && (bus.i_data == 8'h55) && (aaCnt_q == 2'd2) && (state_q != S_SOF);
    assign dataStrobe = strobe && !isHeader && !isStuff && (state_q != S_SOF);
    assign lenTooBig  = (32'(bus.i_data) > 32'(MAX_PAYLOAD));
    assign crcOk      = (crcRx_q == ~crcCalc_q);
    assign crcNext    = crcByte(crcCalc_q, bus.i_data);

    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = errCode_q;
    assign bus.o_id       = outId_q;
    assign bus.o_len      = outLen_q;
    assign bus.o_data     = outData_q;
    assign bus.o_busy     = (state_q != S_SOF);

    // State and datapath registers; reset clears everything including outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_SOF;
            aaCnt_q   <= '0;
            crcCalc_q <= CRC_INIT;
            crcRx_q   <= '0;
            id_q      <= '0;
            len_q     <= '0;
            payload_q <= '0;
            byteCnt_q <= '0;
            crcCnt_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= '0;
            outId_q   <= '0;
            outLen_q  <= '0;
            outData_q <= '0;
        end else begin
            state_q   <= state_d;
            aaCnt_q   <= aaCnt_d;
            crcCalc_q <= crcCalc_d;
            crcRx_q   <= crcRx_d;
            id_q      <= id_d;
            len_q     <= len_d;
            payload_q <= payload_d;
            byteCnt_q <= byteCnt_d;
            crcCnt_q  <= crcCnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
            outId_q   <= outId_d;
            outLen_q  <= outLen_d;
            outData_q <= outData_d;
        end
    end

    // Next state: header detection and stuff removal first, then the per-state frame parser
    always_comb begin
        state_d   = state_q;
        aaCnt_d   = aaCnt_q;
        crcCalc_d = crcCalc_q;
        crcRx_d   = crcRx_q;
        id_d      = id_q;
        len_d     = len_q;
        payload_d = payload_q;
        byteCnt_d = byteCnt_q;
        crcCnt_d  = crcCnt_q;

        if (isHeader) begin
            state_d   = S_ID;
            aaCnt_d   = '0;
            crcCalc_d = CRC_INIT;
        end else if (isStuff) begin
            aaCnt_d = '0;
        end else if (strobe) begin
            if (bus.i_data == 8'hAA) begin
                aaCnt_d = (aaCnt_q == 2'd2) ? 2'd2 : aaCnt_q + 2'd1;
            end else begin
                aaCnt_d = '0;
            end
        end

        if (dataStrobe) begin
            case (state_q)
                S_ID: begin
                    id_d      = bus.i_data;
                    crcCalc_d = crcNext;
                    state_d   = S_LEN;
                end
                S_LEN: begin
                    len_d     = LEN_WIDTH'(bus.i_data);
                    crcCalc_d = crcNext;
                    payload_d = '0;
                    byteCnt_d = '0;
                    crcCnt_d  = '0;
                    if (lenTooBig) begin
                        state_d = S_SOF;
                    end else if (bus.i_data == 8'h00) begin
                        state_d = S_CRC;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        if (byteCnt_q == LEN_WIDTH'(k)) begin
                            payload_d[8*(MAX_PAYLOAD-1-k) +: 8] = bus.i_data;
                        end
                    end
                    crcCalc_d = crcNext;
                    byteCnt_d = byteCnt_q + LEN_WIDTH'(1);
                    if ((byteCnt_q + LEN_WIDTH'(1)) == len_q) begin
                        state_d = S_CRC;
                    end
                end
                S_CRC: begin
                    crcRx_d  = {crcRx_q[23:0], bus.i_data};
                    crcCnt_d = crcCnt_q + 2'd1;
                    if (crcCnt_q == 2'd3) begin
                        state_d = S_EOF;
                    end
                end
                S_EOF: begin
                    state_d = S_SOF;
                end
                default: begin
                    state_d = S_SOF;
                end
            endcase
        end
    end

    // Output decode: valid/error pulses and the held frame outputs, registered one cycle after the strobe
    always_comb begin
        valid_d   = 1'b0;
        err_d     = 1'b0;
        errCode_d = errCode_q;
        outId_d   = outId_q;
        outLen_d  = outLen_q;
        outData_d = outData_q;

        if (dataStrobe && (state_q == S_LEN) && lenTooBig) begin
            err_d     = 1'b1;
            errCode_d = 2'd2;
        end else if (dataStrobe && (state_q == S_EOF)) begin
            if (bus.i_data != 8'h55) begin
                err_d     = 1'b1;
                errCode_d = 2'd3;
            end else if (!crcOk) begin
                err_d     = 1'b1;
                errCode_d = 2'd1;
            end else begin
                valid_d   = 1'b1;
                outId_d   = id_q;
                outLen_d  = len_q;
                outData_d = payload_q;
            end
        end
    end

endmodule

// File: tb/tb_min_receive_fsm.sv
// Directed bench for the MIN receive decoder: good frames, stuffing, CRC/length/EOF errors,
// aborted frames, enable freeze, back-to-back frames and reset mid-frame.
module tb_min_receive_fsm;

    logic clk;
    logic rstN;
    int   assertCount;
    int   failCount;
    int   validSeen;
    int   errSeen;
    int   bothSeen;
    int   stuffCnt;

    min_receive_fsm_if #(.MAX_PAYLOAD(4), .LEN_WIDTH(8)) busIf ();

    min_receive_fsm #(.MAX_PAYLOAD(4), .LEN_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (busIf)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count output pulses on the falling edge, away from the register updates
    always @(negedge clk) begin
        if (busIf.o_valid) validSeen++;
        if (busIf.o_err) errSeen++;
        if (busIf.o_valid && busIf.o_err) bothSeen++;
    end

    // Reference CRC-32 step, written bit by bit against the reflected polynomial
    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        mix;
        r = c;
        for (int i = 0; i < 8; i++) begin
            mix = r[0] ^ b[i];
            r   = r >> 1;
            if (mix) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One raw byte strobe; called at a falling edge, returns at the next falling edge
    task automatic applyStimulus(input logic [7:0] b);
        busIf.i_valid = 1'b1;
        busIf.i_data  = b;
        @(negedge clk);
        busIf.i_valid = 1'b0;
    endtask

    // Sender-side stuffing: a 0x55 follows every two consecutive 0xAA bytes
    task automatic sendStuffed(input logic [7:0] b);
        applyStimulus(b);
        if (b == 8'hAA) stuffCnt++;
        else stuffCnt = 0;
        if (stuffCnt == 2) begin
            applyStimulus(8'h55);
            stuffCnt = 0;
        end
    endtask

    task automatic sendHeader();
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        stuffCnt = 0;
    endtask

    // Strobes with enable low, including a would-be header, must be ignored
    task automatic freezeWindow();
        busIf.i_en = 1'b0;
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        checkOutput("freeze_busy", 64'(busIf.o_busy), 64'd1);
        busIf.i_en = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] id, input int len, input logic [31:0] pl,
                             input logic [7:0] crcFlip, input logic [7:0] eofByte, input int pauseAt);
        logic [31:0] crc;
        logic [31:0] tx;
        logic [7:0]  b;
        sendHeader();
        crc = 32'hFFFFFFFF;
        sendStuffed(id);
        crc = crcStep(crc, id);
        sendStuffed(8'(len));
        crc = crcStep(crc, 8'(len));
        for (int i = 0; i < len; i++) begin
            b = pl[31-8*i -: 8];
            if (i == pauseAt) freezeWindow();
            sendStuffed(b);
            crc = crcStep(crc, b);
        end
        tx = ~crc;
        tx[7:0] = tx[7:0] ^ crcFlip;
        for (int j = 0; j < 4; j++) begin
            sendStuffed(tx[31-8*j -: 8]);
        end
        applyStimulus(eofByte);
    endtask

    task automatic checkGood(input string tag, input logic [7:0] id, input int len, input logic [31:0] data);
        checkOutput({tag, "_valid"}, 64'(busIf.o_valid), 64'd1);
        checkOutput({tag, "_err"}, 64'(busIf.o_err), 64'd0);
        checkOutput({tag, "_id"}, 64'(busIf.o_id), 64'(id));
        checkOutput({tag, "_len"}, 64'(busIf.o_len), 64'(len));
        checkOutput({tag, "_data"}, 64'(busIf.o_data), 64'(data));
    endtask

    // Linear directed sequence
    initial begin
        assertCount   = 0;
        failCount     = 0;
        validSeen     = 0;
        errSeen       = 0;
        bothSeen      = 0;
        stuffCnt      = 0;
        busIf.i_en    = 1'b1;
        busIf.i_valid = 1'b0;
        busIf.i_data  = 8'h00;
        rstN          = 1'b0;

        #3;
        checkOutput("rst_valid", 64'(busIf.o_valid), 64'd0);
        checkOutput("rst_err", 64'(busIf.o_err), 64'd0);
        checkOutput("rst_code", 64'(busIf.o_err_code), 64'd0);
        checkOutput("rst_id", 64'(busIf.o_id), 64'd0);
        checkOutput("rst_data", 64'(busIf.o_data), 64'd0);
        checkOutput("rst_busy", 64'(busIf.o_busy), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Plain good frame
        sendFrame(8'h08, 4, 32'h12345678, 8'h00, 8'h55, -1);
        checkGood("f1", 8'h08, 4, 32'h12345678);
        @(negedge clk);
        checkOutput("f1_pulse_end", 64'(busIf.o_valid), 64'd0);
        #1;
        checkOutput("f1_valid_count", 64'(validSeen), 64'd1);
        checkOutput("f1_err_count", 64'(errSeen), 64'd0);

        // Payload containing AA AA forces a stuffed 0x55
        sendFrame(8'h10, 4, 32'hAAAA0100, 8'h00, 8'h55, -1);
        checkGood("stuff", 8'h10, 4, 32'hAAAA0100);

        // Corrupted CRC byte: error code 1, previous frame outputs held
        sendFrame(8'h22, 2, 32'h55AA0000, 8'h01, 8'h55, -1);
        checkOutput("crc_err", 64'(busIf.o_err), 64'd1);
        checkOutput("crc_code", 64'(busIf.o_err_code), 64'd1);
        checkOutput("crc_valid", 64'(busIf.o_valid), 64'd0);
        checkOutput("crc_id_hold", 64'(busIf.o_id), 64'h10);
        checkOutput("crc_data_hold", 64'(busIf.o_data), 64'hAAAA0100);

        // Length above maximum: error code 2 one cycle after the LEN strobe
        sendHeader();
        sendStuffed(8'h30);
        sendStuffed(8'h05);
        checkOutput("len_err", 64'(busIf.o_err), 64'd1);
        checkOutput("len_code", 64'(busIf.o_err_code), 64'd2);
        checkOutput("len_busy", 64'(busIf.o_busy), 64'd0);
        @(negedge clk);
        sendFrame(8'h31, 3, 32'hC0FFEE00, 8'h00, 8'h55, -1);
        checkGood("after_len", 8'h31, 3, 32'hC0FFEE00);
        checkOutput("code_hold", 64'(busIf.o_err_code), 64'd2);

        // Wrong EOF byte: error code 3
        sendFrame(8'h50, 2, 32'hBEEF0000, 8'h00, 8'h66, -1);
        checkOutput("eof_err", 64'(busIf.o_err), 64'd1);
        checkOutput("eof_code", 64'(busIf.o_err_code), 64'd3);
        checkOutput("eof_id_hold", 64'(busIf.o_id), 64'h31);

        // Truncated frame aborted silently by a new header; short payload zero-filled
        sendHeader();
        sendStuffed(8'h60);
        sendStuffed(8'h04);
        sendStuffed(8'h01);
        sendStuffed(8'h02);
        sendFrame(8'h20, 1, 32'h7FDEADBE, 8'h00, 8'h55, -1);
        checkGood("abort", 8'h20, 1, 32'h7F000000);
        #1;
        checkOutput("abort_err_count", 64'(errSeen), 64'd3);
        @(negedge clk);

        // Enable dropped mid-payload, then a frame starting right after the EOF strobe
        sendFrame(8'h70, 4, 32'h0A0B0C0D, 8'h00, 8'h55, 2);
        checkGood("freeze", 8'h70, 4, 32'h0A0B0C0D);
        sendFrame(8'h71, 1, 32'hEE123456, 8'h00, 8'h55, -1);
        checkGood("b2b", 8'h71, 1, 32'hEE000000);

        // Reset asserted while in the payload state
        sendHeader();
        sendStuffed(8'h40);
        sendStuffed(8'h04);
        sendStuffed(8'h11);
        checkOutput("pre_rst_busy", 64'(busIf.o_busy), 64'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(busIf.o_busy), 64'd0);
        checkOutput("mid_rst_id", 64'(busIf.o_id), 64'd0);
        checkOutput("mid_rst_len", 64'(busIf.o_len), 64'd0);
        checkOutput("mid_rst_data", 64'(busIf.o_data), 64'd0);
        checkOutput("mid_rst_code", 64'(busIf.o_err_code), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", 64'(busIf.o_busy), 64'd0);
        sendFrame(8'h41, 3, 32'hAA55AA00, 8'h00, 8'h55, -1);
        checkGood("post_rst", 8'h41, 3, 32'hAA55AA00);

        @(negedge clk);
        #1;
        checkOutput("total_valid", 64'(validSeen), 64'd7);
        checkOutput("total_err", 64'(errSeen), 64'd3);
        checkOutput("never_both", 64'(bothSeen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
